// File: rtl/ascii_duty_pkg.sv
// Shared constants for the ASCII duty-cycle command decoder: byte codes, FSM
// encoding and the duty/accumulator widths.
package ascii_duty_pkg;

    localparam int DUTY_W = 7;
    localparam int ACC_W  = 10;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_D_UP  = 8'h44;
    localparam logic [7:0] ASCII_D_LO  = 8'h64;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NUM     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_ZERO + 8'd9);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags the cycle on which the TIMEOUT_CYCLES-th idle cycle is reached.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);
    assign expired   = enable && !clear && w_at_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !w_at_last) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ascii_duty_decoder.sv
// Parses UART command bytes ("Dnnn<CR/LF>", '+', '-') into a registered PWM
// duty value. Define CMD_TIMEOUT_EN to abandon stalled commands after TIMEOUT_CYCLES.
module ascii_duty_decoder
    import ascii_duty_pkg::*;
#(
    parameter int DUTY_MAX       = 100,
    parameter int STEP           = 5,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              duty_update,
    output logic              cmd_err
);

    state_t             r_state, w_state_next;
    logic [ACC_W-1:0]   r_acc, w_acc_next;
    logic [1:0]         r_count, w_count_next;
    logic [DUTY_W-1:0]  r_duty, w_duty_next;
    logic               r_update, w_update_next;
    logic               r_err, w_err_next;
    logic               w_timeout;
    logic [ACC_W-1:0]   w_inc;

`ifdef CMD_TIMEOUT_EN
    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid || (r_state == ST_IDLE)),
        .enable (r_state != ST_IDLE),
        .expired(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: non-blocking assignments for all state so every register samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_count  <= '0;
            r_duty   <= '0;
            r_update <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_acc    <= w_acc_next;
            r_count  <= w_count_next;
            r_duty   <= w_duty_next;
            r_update <= w_update_next;
            r_err    <= w_err_next;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (rx_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rx_data == ASCII_D_UP || rx_data == ASCII_D_LO)
                        w_state_next = ST_NUM;
                end
                ST_NUM: begin
                    if (is_digit(rx_data))
                        w_state_next = (r_count == 2'd3) ? ST_DISCARD : ST_NUM;
                    else if (is_term(rx_data))
                        w_state_next = ST_IDLE;
                    else
                        w_state_next = ST_DISCARD;
                end
                ST_DISCARD: begin
                    if (is_term(rx_data))
                        w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_next = ST_IDLE;
        end
    end

    // Saturating '+' sum is formed wide so DUTY_MAX near the 7-bit limit cannot wrap.
    assign w_inc = ACC_W'(r_duty) + ACC_W'(STEP);

    always_comb begin
        w_acc_next    = r_acc;
        w_count_next  = r_count;
        w_duty_next   = r_duty;
        w_update_next = 1'b0;
        w_err_next    = 1'b0;
        if (rx_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    case (rx_data)
                        ASCII_D_UP, ASCII_D_LO: begin
                            w_acc_next   = '0;
                            w_count_next = '0;
                        end
                        ASCII_CR, ASCII_LF: ;
                        ASCII_PLUS: begin
                            w_duty_next   = (w_inc > ACC_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX)
                                                                       : w_inc[DUTY_W-1:0];
                            w_update_next = 1'b1;
                        end
                        ASCII_MINUS: begin
                            w_duty_next   = (ACC_W'(r_duty) < ACC_W'(STEP)) ? '0
                                                                            : r_duty - DUTY_W'(STEP);
                            w_update_next = 1'b1;
                        end
                        default: w_err_next = 1'b1;
                    endcase
                end
                ST_NUM: begin
                    if (is_digit(rx_data)) begin
                        if (r_count == 2'd3) begin
                            w_err_next = 1'b1;
                        end else begin
                            w_acc_next   = r_acc * ACC_W'(10) + ACC_W'(rx_data[3:0]);
                            w_count_next = r_count + 2'd1;
                        end
                    end else if (is_term(rx_data)) begin
                        if (r_count != 2'd0 && r_acc <= ACC_W'(DUTY_MAX)) begin
                            w_duty_next   = r_acc[DUTY_W-1:0];
                            w_update_next = 1'b1;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (w_timeout && r_state == ST_NUM) begin
            w_err_next = 1'b1;
        end
    end

    assign duty_cycle  = r_duty;
    assign duty_update = r_update;
    assign cmd_err     = r_err;

endmodule

// File: tb/tb_ascii_duty_decoder.sv
// Scoreboard bench for ascii_duty_decoder: a text-level command model predicts
// pulses, a negedge monitor pops and compares them. Honours CMD_TIMEOUT_EN.
module tb_ascii_duty_decoder;

    localparam int DUTY_MAX = 100;
    localparam int STEP     = 5;
    localparam int TO       = 100;

    localparam int M_IDLE    = 0;
    localparam int M_CMD     = 1;
    localparam int M_SKIP    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [6:0] duty_cycle;
    logic       duty_update;
    logic       cmd_err;

    ascii_duty_decoder #(
        .DUTY_MAX      (DUTY_MAX),
        .STEP          (STEP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .duty_cycle (duty_cycle),
        .duty_update(duty_update),
        .cmd_err    (cmd_err)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int duty;
        int cyc;
    } ev_t;
    ev_t q[$];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model (command-text level) ----------------
    int    mode     = M_IDLE;
    int    mduty    = 0;
    string cmd_buf  = "";
    int    idle_run = 0;

    function automatic bit is_term_b(input byte b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    function automatic bit is_digit_b(input byte b);
        return (b >= "0") && (b <= "9");
    endfunction

    task automatic expect_ev(input bit is_err, input int duty);
        ev_t e;
        e.is_err = is_err;
        e.duty   = duty;
        e.cyc    = cyc + 1;
        q.push_back(e);
    endtask

    task automatic model_byte(input byte b);
        int val;
        case (mode)
            M_IDLE: begin
                if (b == "D" || b == "d") begin
                    mode    = M_CMD;
                    cmd_buf = "";
                end else if (is_term_b(b)) begin
                end else if (b == "+") begin
                    mduty = (mduty + STEP > DUTY_MAX) ? DUTY_MAX : mduty + STEP;
                    expect_ev(1'b0, mduty);
                end else if (b == "-") begin
                    mduty = (mduty - STEP < 0) ? 0 : mduty - STEP;
                    expect_ev(1'b0, mduty);
                end else begin
                    expect_ev(1'b1, 0);
                end
            end
            M_CMD: begin
                if (is_digit_b(b)) begin
                    if (cmd_buf.len() == 3) begin
                        expect_ev(1'b1, 0);
                        mode = M_SKIP;
                    end else begin
                        cmd_buf = $sformatf("%s%c", cmd_buf, b);
                    end
                end else if (is_term_b(b)) begin
                    val = cmd_buf.atoi();
                    if (cmd_buf.len() > 0 && val <= DUTY_MAX) begin
                        mduty = val;
                        expect_ev(1'b0, mduty);
                    end else begin
                        expect_ev(1'b1, 0);
                    end
                    mode = M_IDLE;
                end else begin
                    expect_ev(1'b1, 0);
                    mode = M_SKIP;
                end
            end
            default: begin
                if (is_term_b(b)) mode = M_IDLE;
            end
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input byte b);
        model_byte(b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        idle_run = 0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            idle_run++;
`ifdef CMD_TIMEOUT_EN
            if (idle_run == TO && mode != M_IDLE) begin
                if (mode == M_CMD) expect_ev(1'b1, 0);
                mode = M_IDLE;
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_duty(input string name);
        idle(2);
        check(name, int'(duty_cycle), mduty);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mode     = M_IDLE;
        mduty    = 0;
        idle_run = 0;
        check("reset_duty", int'(duty_cycle), 0);
        check("reset_update", int'(duty_update), 0);
        check("reset_err", int'(cmd_err), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ev_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("pulse_missing_at_cycle", cyc, e.cyc);
        end
        if (duty_update || cmd_err) begin
            check("update_err_exclusive", int'(duty_update && cmd_err), 0);
            if (q.size() == 0) begin
                check("unexpected_pulse_err_upd", int'(cmd_err) * 2 + int'(duty_update), 0);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_is_err", int'(cmd_err), int'(e.is_err));
                if (!e.is_err) check("pulse_duty", int'(duty_cycle), e.duty);
            end
        end
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    string alpha = "DDDd++--0123456789012\r\n\r\nx ";

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        send_str("D75\r");
        check_duty("duty_after_D75");

        send_str("D101\n");
        check_duty("duty_after_D101");

        send_str("D1000\r");
        check_duty("duty_after_D1000");

        send_str("D98\r");
        send("+");
        send("+");
        check_duty("duty_saturate_high");

        send_str("D3\r");
        send("-");
        check_duty("duty_saturate_low");

        send_str("D5x9\r");
        send_str("D\r");
        check_duty("duty_after_discard");

        send_str("d42\n");
        send("\n");
        idle(1);
        send("-");
        check_duty("duty_lower_d");

        send_str("D6");
        idle(1);
        do_reset();
        send_str("0\r");
        check_duty("duty_after_midcmd_reset");

`ifdef CMD_TIMEOUT_EN
        send_str("D75\r");
        send_str("D4");
        idle(TO);
        send_str("7\r");
        check_duty("duty_after_timeout");
        send_str("Dx");
        idle(TO + 3);
        send("+");
        check_duty("duty_after_discard_timeout");
`endif

        for (int i = 0; i < 600; i++) begin
            send(alpha[$urandom_range(0, alpha.len() - 1)]);
            idle($urandom_range(0, 2));
            if (i % 60 == 59) check_duty("duty_random_track");
        end
        send("\r");
        idle(3);
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/ascii_duty_decoder.md
ASCII_DUTY_DECODER -- requirements
Module: ascii_duty_decoder

Interface
REQ-001 SHALL have parameter DUTY_MAX, default 100, maximum legal duty value.
REQ-002 SHALL have parameter STEP, default 5, increment/decrement size for '+'/'-'.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2500000, inter-byte timeout (100 ms at 25 MHz).
REQ-004 SHALL have port clk, input, 1, sole clock (25 MHz domain).
REQ-005 SHALL have port rst, input, 1, reset: one clock; reset is synchronous and active-high.
REQ-006 SHALL have port rx_data, input, 8, received UART byte, valid only with rx_valid.
REQ-007 SHALL have port rx_valid, input, 1, single-cycle strobe qualifying rx_data.
REQ-008 SHALL have port duty_cycle, output, 7, registered duty value 0..DUTY_MAX to PWM stage.
REQ-009 SHALL have port duty_update, output, 1, one-cycle pulse when duty_cycle changes value or is rewritten.
REQ-010 SHALL have port cmd_err, output, 1, one-cycle pulse per rejected command.

Function
REQ-011 SHALL implement FSM states IDLE, NUM, DISCARD; one byte processed per rx_valid cycle; no action when rx_valid low.
REQ-012 IDLE: 'D'/'d' -> NUM, accumulator and digit count cleared; CR (0x0D)/LF (0x0A) ignored silently; '+' -> duty_cycle = min(duty+STEP, DUTY_MAX); '-' -> duty_cycle = max(duty-STEP, 0); any other byte -> cmd_err, stay IDLE.
REQ-013 NUM: digit '0'..'9' -> acc = acc*10 + digit in 10-bit arithmetic, count+1; 4th digit -> cmd_err, go DISCARD.
REQ-014 NUM: CR/LF with count>=1 and acc<=DUTY_MAX -> duty_cycle = acc, duty_update, go IDLE.
REQ-015 NUM: CR/LF with count=0 or acc>DUTY_MAX -> cmd_err, duty_cycle unchanged, go IDLE.
REQ-016 NUM: any other byte (including 'D') -> cmd_err, go DISCARD.
REQ-017 DISCARD: drop all bytes silently; CR/LF -> IDLE; no further cmd_err.
REQ-018 duty_cycle, duty_update, cmd_err SHALL be registered, asserted on the cycle after the deciding rx_valid (latency 1).
REQ-019 '+' at DUTY_MAX and '-' at 0 SHALL saturate, still pulse duty_update, no cmd_err.
REQ-020 duty_update and cmd_err SHALL never assert in the same cycle.

Reset
REQ-021 rst SHALL force IDLE, acc=0, count=0, duty_cycle=0, duty_update=0, cmd_err=0, timer=0 on the next clk edge, regardless of state (mid-command input discarded).

Configuration
REQ-022 With CMD_TIMEOUT_EN defined: in NUM or DISCARD, TIMEOUT_CYCLES consecutive cycles without rx_valid SHALL return FSM to IDLE; cmd_err pulses only if leaving NUM; timer cleared on every rx_valid and in IDLE; rx_valid on the expiry cycle wins (byte processed, timer cleared).
REQ-023 Without CMD_TIMEOUT_EN: no timer logic; NUM/DISCARD held indefinitely until a terminator.

Structure
REQ-024 Shared package ascii_duty_pkg SHALL hold ASCII constants (CR, LF, 'D', 'd', '+', '-', '0'), FSM state encoding, and DUTY_W=7.
REQ-025 Timeout counter SHALL be sub-module cmd_timeout_timer (inputs clk, rst, clear, enable; output expired), instantiated only under CMD_TIMEOUT_EN.

Verification
REQ-026 Bytes "D75\r" -> duty_cycle=75, one duty_update pulse one cycle after CR rx_valid, no cmd_err.
REQ-027 "D101\n" -> one cmd_err, duty_cycle keeps previous value; "D1000\r" -> one cmd_err (at 4th digit), no second error at CR.
REQ-028 From duty 98: '+' -> 100, '+' -> 100 (duty_update both times); from 3: '-' -> 0.
REQ-029 "D5x9\r" -> cmd_err at 'x', bytes to CR discarded, then "D\r" -> cmd_err, duty unchanged.
REQ-030 CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: "D4" then 100 idle cycles -> cmd_err, IDLE; subsequent "7\r" -> two cmd_err-free? No: '7' in IDLE -> cmd_err, CR ignored, duty unchanged.
REQ-031 rst asserted between "D6" and "0\r" -> duty_cycle=0, '0' -> cmd_err, CR ignored.
